// File: rtl/wb_ic_pkg.sv
// rtl/wb_ic_pkg.sv - shared types, default address map and helpers for the Wishbone interconnect
package wb_ic_pkg;

    typedef enum logic [1:0] {
        IC_IDLE   = 2'd0,
        IC_ACTIVE = 2'd1,
        IC_DECERR = 2'd2
    } ic_state_t;

    localparam logic [63:0] IC_DEFAULT_BASE = {32'h0100_0000, 32'h0010_0000};
    localparam logic [63:0] IC_DEFAULT_MASK = {32'hFFFF_0000, 32'hFFFF_0000};

    // A single-slave map still needs a one-bit index.
    function automatic int ic_idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_addr_decoder.sv
// rtl/wb_addr_decoder.sv - combinational base/mask slave decoder, lowest matching index wins
module wb_addr_decoder
    import wb_ic_pkg::*;
#(
    parameter int                                    AW         = 32,
    parameter int                                    NUM_SLAVES = 2,
    parameter logic [NUM_SLAVES*AW-1:0]              SLAVE_BASE = IC_DEFAULT_BASE,
    parameter logic [NUM_SLAVES*AW-1:0]              SLAVE_MASK = IC_DEFAULT_MASK,
    parameter int                                    IW         = ic_idx_width(NUM_SLAVES)
) (
    input  logic [AW-1:0] adr,
    output logic          hit,
    output logic [IW-1:0] idx
);

    // Scan from the top down so the lowest matching entry is the last one written.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((adr & SLAVE_MASK[i*AW +: AW]) == SLAVE_BASE[i*AW +: AW]) begin
                hit = 1'b1;
                idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/wb_interconnect_nslave.sv
// rtl/wb_interconnect_nslave.sv - registered 1-master / N-slave Wishbone classic interconnect with decode error and watchdog
module wb_interconnect_nslave
    import wb_ic_pkg::*;
#(
    parameter int                                                   WISHBONE_ADDR_WIDTH = 32,
    parameter int                                                   WISHBONE_BUS_WIDTH  = 32,
    parameter int                                                   NUM_SLAVES          = 2,
    parameter logic [NUM_SLAVES*WISHBONE_ADDR_WIDTH-1:0]            SLAVE_BASE          = IC_DEFAULT_BASE,
    parameter logic [NUM_SLAVES*WISHBONE_ADDR_WIDTH-1:0]            SLAVE_MASK          = IC_DEFAULT_MASK,
    parameter int                                                   TIMEOUT_CYCLES      = 255
) (
    input  logic                                         clk_i,
    input  logic                                         rst_i,
    input  logic                                         wbm_cyc,
    input  logic                                         wbm_stb,
    input  logic [WISHBONE_ADDR_WIDTH-1:0]               wbm_adr,
    input  logic                                         wbm_we,
    input  logic [WISHBONE_BUS_WIDTH-1:0]                wbm_dat_o,
    input  logic [WISHBONE_BUS_WIDTH/8-1:0]              wbm_sel,
    output logic [WISHBONE_BUS_WIDTH-1:0]                wbm_dat_i,
    output logic                                         wbm_ack,
    output logic                                         wbm_err,
    output logic [WISHBONE_ADDR_WIDTH-1:0]               ic_wbs_adr,
    output logic                                         ic_wbs_we,
    output logic [WISHBONE_BUS_WIDTH-1:0]                ic_wbs_dat_i,
    output logic [WISHBONE_BUS_WIDTH/8-1:0]              ic_wbs_sel,
    output logic [NUM_SLAVES-1:0]                        wbs_cyc,
    output logic [NUM_SLAVES-1:0]                        wbs_stb,
    input  logic [NUM_SLAVES*WISHBONE_BUS_WIDTH-1:0]     wbs_dat_o,
    input  logic [NUM_SLAVES-1:0]                        wbs_ack,
    input  logic [NUM_SLAVES-1:0]                        wbs_err
);

    localparam int AW = WISHBONE_ADDR_WIDTH;
    localparam int DW = WISHBONE_BUS_WIDTH;
    localparam int IW = ic_idx_width(NUM_SLAVES);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    ic_state_t       r_state;
    ic_state_t       w_state_nxt;
    logic [IW-1:0]   r_sel_q;
    logic [IW-1:0]   w_sel_nxt;
    logic [CW-1:0]   r_tmo_cnt;
    logic [CW-1:0]   w_tmo_nxt;
    logic            w_hit;
    logic [IW-1:0]   w_idx;
    logic            w_slv_ack;
    logic            w_slv_err;
    logic [DW-1:0]   w_slv_dat;

    assign ic_wbs_adr   = wbm_adr;
    assign ic_wbs_we    = wbm_we;
    assign ic_wbs_dat_i = wbm_dat_o;
    assign ic_wbs_sel   = wbm_sel;

    wb_addr_decoder #(
        .AW         (AW),
        .NUM_SLAVES (NUM_SLAVES),
        .SLAVE_BASE (SLAVE_BASE),
        .SLAVE_MASK (SLAVE_MASK),
        .IW         (IW)
    ) u_decoder (
        .adr (wbm_adr),
        .hit (w_hit),
        .idx (w_idx)
    );

    assign w_slv_ack = wbs_ack[r_sel_q];
    assign w_slv_err = wbs_err[r_sel_q];
    assign w_slv_dat = wbs_dat_o[r_sel_q*DW +: DW];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= IC_IDLE;
            r_sel_q   <= '0;
            r_tmo_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_sel_q   <= w_sel_nxt;
            r_tmo_cnt <= w_tmo_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel_q;
        w_tmo_nxt   = r_tmo_cnt;
        wbm_ack     = 1'b0;
        wbm_err     = 1'b0;
        wbm_dat_i   = '0;
        wbs_cyc     = '0;
        wbs_stb     = '0;

        case (r_state)
            IC_IDLE: begin
                if (wbm_cyc && wbm_stb) begin
                    w_sel_nxt   = w_idx;
                    w_tmo_nxt   = '0;
                    w_state_nxt = w_hit ? IC_ACTIVE : IC_DECERR;
                end
            end

            IC_ACTIVE: begin
                if (!wbm_cyc) begin
                    w_state_nxt = IC_IDLE;
                    w_tmo_nxt   = '0;
                end else if (r_tmo_cnt == TMO_LAST) begin
                    // Watchdog expiry: slave is detached and its late response ignored.
                    wbm_err     = 1'b1;
                    w_state_nxt = IC_IDLE;
                    w_tmo_nxt   = '0;
                end else begin
                    wbs_cyc[r_sel_q] = 1'b1;
                    wbs_stb[r_sel_q] = wbm_stb;
                    if (w_slv_err) begin
                        wbm_err     = 1'b1;
                        w_state_nxt = IC_IDLE;
                        w_tmo_nxt   = '0;
                    end else if (w_slv_ack) begin
                        wbm_ack     = 1'b1;
                        wbm_dat_i   = w_slv_dat;
                        w_state_nxt = IC_IDLE;
                        w_tmo_nxt   = '0;
                    end else begin
                        w_tmo_nxt = r_tmo_cnt + 1'b1;
                    end
                end
            end

            IC_DECERR: begin
                wbm_err     = 1'b1;
                w_state_nxt = IC_IDLE;
            end

            default: begin
                w_state_nxt = IC_IDLE;
                w_tmo_nxt   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_wb_interconnect_nslave.sv
// tb/tb_wb_interconnect_nslave.sv - directed table-driven bench for wb_interconnect_nslave
module tb_wb_interconnect_nslave;

    localparam logic [31:0] SDAT0 = 32'h1111_2222;
    localparam logic [31:0] SDAT1 = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        wbm_cyc, wbm_stb, wbm_we;
    logic [31:0] wbm_adr, wbm_dat_o;
    logic [3:0]  wbm_sel;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack, wbm_err;
    logic [31:0] ic_wbs_adr, ic_wbs_dat_i;
    logic        ic_wbs_we;
    logic [3:0]  ic_wbs_sel;
    logic [1:0]  wbs_cyc, wbs_stb, wbs_ack, wbs_err;
    logic [63:0] wbs_dat_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_interconnect_nslave #(
        .NUM_SLAVES     (2),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .wbm_cyc      (wbm_cyc),
        .wbm_stb      (wbm_stb),
        .wbm_adr      (wbm_adr),
        .wbm_we       (wbm_we),
        .wbm_dat_o    (wbm_dat_o),
        .wbm_sel      (wbm_sel),
        .wbm_dat_i    (wbm_dat_i),
        .wbm_ack      (wbm_ack),
        .wbm_err      (wbm_err),
        .ic_wbs_adr   (ic_wbs_adr),
        .ic_wbs_we    (ic_wbs_we),
        .ic_wbs_dat_i (ic_wbs_dat_i),
        .ic_wbs_sel   (ic_wbs_sel),
        .wbs_cyc      (wbs_cyc),
        .wbs_stb      (wbs_stb),
        .wbs_dat_o    (wbs_dat_o),
        .wbs_ack      (wbs_ack),
        .wbs_err      (wbs_err)
    );

    typedef struct {
        logic        rst;
        logic        cyc;
        logic        stb;
        logic        we;
        logic [31:0] adr;
        logic [31:0] wdat;
        logic [3:0]  sel;
        logic [1:0]  sack;
        logic [1:0]  serr;
        logic        e_ack;
        logic        e_err;
        logic [31:0] e_dat;
        logic [1:0]  e_cyc;
        logic [1:0]  e_stb;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic cyc, input logic stb, input logic we,
                       input logic [31:0] adr, input logic [1:0] sack, input logic [1:0] serr,
                       input logic e_ack, input logic e_err, input logic [31:0] e_dat,
                       input logic [1:0] e_cyc, input logic [1:0] e_stb);
        vec_t v;
        v.rst = rst; v.cyc = cyc; v.stb = stb; v.we = we; v.adr = adr;
        v.wdat = {16'hA5A5, 16'(vecs.size())};
        v.sel = 4'(vecs.size());
        v.sack = sack; v.serr = serr;
        v.e_ack = e_ack; v.e_err = e_err; v.e_dat = e_dat; v.e_cyc = e_cyc; v.e_stb = e_stb;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        rst_i = 1'b0; wbm_cyc = 1'b0; wbm_stb = 1'b0; wbm_we = 1'b0;
        wbm_adr = '0; wbm_dat_o = '0; wbm_sel = '0; wbs_ack = '0; wbs_err = '0;
    endtask

    initial begin
        int found;
        wbs_dat_o = {SDAT1, SDAT0};
        drive_idle();
        rst_i = 1'b1;
        repeat (2) @(posedge clk);

        // rst cyc stb we adr           sack   serr   ack  err  dat    cyc    stb
        add(1, 0, 0, 0, 32'h0000_0000, 2'b00, 2'b00, 0, 0, 32'h0,  2'b00, 2'b00); // reset state
        add(0, 1, 1, 0, 32'h0100_0004, 2'b00, 2'b00, 0, 0, 32'h0,  2'b00, 2'b00); // read slave1: decode
        add(0, 1, 1, 0, 32'h0100_0004, 2'b00, 2'b00, 0, 0, 32'h0,  2'b10, 2'b10);
        add(0, 1, 1, 0, 32'h0100_0004, 2'b00, 2'b00, 0, 0, 32'h0,  2'b10, 2'b10);
        add(0, 1, 1, 0, 32'h0100_0004, 2'b10, 2'b00, 1, 0, SDAT1,  2'b10, 2'b10);
        add(0, 0, 0, 0, 32'h0000_0000, 2'b00, 2'b00, 0, 0, 32'h0,  2'b00, 2'b00);
        add(0, 1, 1, 1, 32'h0010_0010, 2'b00, 2'b00, 0, 0, 32'h0,  2'b00, 2'b00); // write slave0
        add(0, 1, 1, 1, 32'h0010_0010, 2'b01, 2'b00, 1, 0, SDAT0,  2'b01, 2'b01);
        add(0, 0, 0, 0, 32'h0000_0000, 2'b00, 2'b00, 0, 0, 32'h0,  2'b00, 2'b00);
        add(0, 1, 1, 0, 32'h0300_0000, 2'b00, 2'b00, 0, 0, 32'h0,  2'b00, 2'b00); // unmapped
        add(0, 1, 1, 0, 32'h0300_0000, 2'b00, 2'b00, 0, 1, 32'h0,  2'b00, 2'b00);
        add(0, 0, 0, 0, 32'h0000_0000, 2'b00, 2'b00, 0, 0, 32'h0,  2'b00, 2'b00);
        add(0, 1, 1, 0, 32'h0010_0000, 2'b00, 2'b00, 0, 0, 32'h0,  2'b00, 2'b00); // stray ack, ack+err
        add(0, 1, 1, 0, 32'h0010_0000, 2'b10, 2'b00, 0, 0, 32'h0,  2'b01, 2'b01);
        add(0, 1, 1, 0, 32'h0010_0000, 2'b01, 2'b01, 0, 1, 32'h0,  2'b01, 2'b01);
        add(0, 0, 0, 0, 32'h0000_0000, 2'b11, 2'b11, 0, 0, 32'h0,  2'b00, 2'b00);
        add(0, 1, 1, 0, 32'h0100_0000, 2'b00, 2'b00, 0, 0, 32'h0,  2'b00, 2'b00); // master abort
        add(0, 1, 1, 0, 32'h0100_0000, 2'b00, 2'b00, 0, 0, 32'h0,  2'b10, 2'b10);
        add(0, 0, 0, 0, 32'h0100_0000, 2'b10, 2'b00, 0, 0, 32'h0,  2'b00, 2'b00);
        add(0, 1, 1, 0, 32'h0010_0000, 2'b01, 2'b00, 0, 0, 32'h0,  2'b00, 2'b00);
        add(0, 1, 1, 0, 32'h0010_0000, 2'b00, 2'b00, 0, 0, 32'h0,  2'b01, 2'b01); // reset mid-ACTIVE
        add(1, 1, 1, 0, 32'h0010_0000, 2'b00, 2'b00, 0, 0, 32'h0,  2'b01, 2'b01);
        add(0, 1, 1, 0, 32'h0010_0000, 2'b01, 2'b00, 0, 0, 32'h0,  2'b00, 2'b00);
        add(0, 1, 1, 0, 32'h0010_0000, 2'b01, 2'b00, 1, 0, SDAT0,  2'b01, 2'b01);
        add(0, 0, 0, 0, 32'h0000_0000, 2'b00, 2'b00, 0, 0, 32'h0,  2'b00, 2'b00);
        add(0, 1, 1, 0, 32'h0100_0008, 2'b00, 2'b00, 0, 0, 32'h0,  2'b00, 2'b00); // watchdog, silent slave1
        add(0, 1, 1, 0, 32'h0100_0008, 2'b00, 2'b00, 0, 0, 32'h0,  2'b10, 2'b10);
        add(0, 1, 1, 0, 32'h0100_0008, 2'b00, 2'b00, 0, 0, 32'h0,  2'b10, 2'b10);
        add(0, 1, 1, 0, 32'h0100_0008, 2'b00, 2'b00, 0, 0, 32'h0,  2'b10, 2'b10);
        add(0, 1, 1, 0, 32'h0100_0008, 2'b00, 2'b00, 0, 1, 32'h0,  2'b00, 2'b00);
        add(0, 0, 0, 0, 32'h0000_0000, 2'b00, 2'b00, 0, 0, 32'h0,  2'b00, 2'b00);
        add(0, 1, 1, 0, 32'h0010_0004, 2'b00, 2'b00, 0, 0, 32'h0,  2'b00, 2'b00);
        add(0, 1, 1, 0, 32'h0010_0004, 2'b01, 2'b00, 1, 0, SDAT0,  2'b01, 2'b01);
        add(0, 0, 0, 0, 32'h0000_0000, 2'b00, 2'b00, 0, 0, 32'h0,  2'b00, 2'b00);

        for (int i = 0; i < vecs.size(); i++) begin
            rst_i     = vecs[i].rst;
            wbm_cyc   = vecs[i].cyc;
            wbm_stb   = vecs[i].stb;
            wbm_we    = vecs[i].we;
            wbm_adr   = vecs[i].adr;
            wbm_dat_o = vecs[i].wdat;
            wbm_sel   = vecs[i].sel;
            wbs_ack   = vecs[i].sack;
            wbs_err   = vecs[i].serr;
            @(negedge clk);
            chk($sformatf("row%0d ack", i), 64'(wbm_ack), 64'(vecs[i].e_ack));
            chk($sformatf("row%0d err", i), 64'(wbm_err), 64'(vecs[i].e_err));
            chk($sformatf("row%0d dat", i), 64'(wbm_dat_i), 64'(vecs[i].e_dat));
            chk($sformatf("row%0d wbs_cyc", i), 64'(wbs_cyc), 64'(vecs[i].e_cyc));
            chk($sformatf("row%0d wbs_stb", i), 64'(wbs_stb), 64'(vecs[i].e_stb));
            chk($sformatf("row%0d broadcast", i), {ic_wbs_adr, ic_wbs_dat_i},
                {vecs[i].adr, vecs[i].wdat});
            chk($sformatf("row%0d bcast_we_sel", i), 64'({ic_wbs_we, ic_wbs_sel}),
                64'({vecs[i].we, vecs[i].sel}));
            @(posedge clk);
            #1;
        end

        // Free-running watchdog: expect the error on the 4th ACTIVE cycle after one decode cycle.
        drive_idle();
        wbm_cyc = 1'b1; wbm_stb = 1'b1; wbm_adr = 32'h0100_0000;
        found = -1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (wbm_err) begin
                found = c;
                chk("tmo wbs_cyc at err", 64'(wbs_cyc), 64'(2'b00));
                chk("tmo no ack at err", 64'(wbm_ack), 64'(1'b0));
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("tmo err cycle", 64'(found), 64'(4));
        @(posedge clk);
        #1;
        wbm_cyc = 1'b0; wbm_stb = 1'b0;
        @(negedge clk);
        chk("tmo after idle err", 64'(wbm_err), 64'(1'b0));
        chk("tmo after idle cyc", 64'(wbs_cyc), 64'(2'b00));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
